hazard_scoreboard: RTL and testbench

HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

---
 rtl/hazard_pkg.sv | 10 +
 rtl/hazard_sb_entry.sv | 50 +++++
 rtl/hazard_scoreboard.sv | 73 +++++++
 tb/tb_hazard_scoreboard.sv | 139 +++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// hazard_pkg: shared defaults and instruction-class encoding for the hazard scoreboard.
package hazard_pkg;
    localparam int REG_AW_DEF   = 5;
    localparam int LOAD_LAT_DEF = 1;
    localparam int MDU_LAT_DEF  = 4;
    typedef enum logic [1:0] {CLS_ALU = 2'd0, CLS_LOAD = 2'd1, CLS_MDU = 2'd2} ins_cls_t;
    function automatic ins_cls_t ins_cls(input logic is_load, input logic is_mdu);
        return is_mdu ? CLS_MDU : is_load ? CLS_LOAD : CLS_ALU;
    endfunction
endpackage

// File: rtl/hazard_sb_entry.sv
// hazard_sb_entry: one scoreboard entry holding a pending destination register and its countdown.
// Ports: clk, rst_n (async active-low); alloc/alloc_reg/alloc_cnt/alloc_mdu load the entry;
// rs/rt/rd are the ID registers compared against the entry; valid/is_mdu report state;
// hit_rs/hit_rt/hit_rd flag matches (register 0 never matches).
module hazard_sb_entry
    import hazard_pkg::*;
#(
    parameter int REG_AW = REG_AW_DEF,
    parameter int CW     = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              alloc,
    input  logic [REG_AW-1:0] alloc_reg,
    input  logic [CW-1:0]     alloc_cnt,
    input  logic              alloc_mdu,
    input  logic [REG_AW-1:0] rs,
    input  logic [REG_AW-1:0] rt,
    input  logic [REG_AW-1:0] rd,
    output logic              valid,
    output logic              is_mdu,
    output logic              hit_rs,
    output logic              hit_rt,
    output logic              hit_rd
);
    logic [REG_AW-1:0] rg;
    logic [CW-1:0]     cnt;
    logic              mdu;

    // Allocation only targets a free entry, so it never races the decrement.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
            rg  <= '0;
            mdu <= 1'b0;
        end else if (alloc) begin
            cnt <= alloc_cnt;
            rg  <= alloc_reg;
            mdu <= alloc_mdu;
        end else if (valid) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign valid  = cnt != '0;
    assign is_mdu = valid & mdu;
    assign hit_rs = valid && rs != '0 && rs == rg;
    assign hit_rt = valid && rt != '0 && rt == rg;
    assign hit_rd = valid && rd != '0 && rd == rg;
endmodule

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: stalls ID on RAW/WAW/structural/MDU hazards against outstanding multi-cycle writers.
// Ports: clk, rst_n (async active-low); id_* describe the ID instruction; flush squashes it;
// PCWr/IF_IDWr/ID_EXMux are 1 to advance, 0 to stall/bubble; pend_cnt counts live entries;
// stall_cnt counts stall cycles since reset, saturating.
module hazard_scoreboard
    import hazard_pkg::*;
#(
    parameter int REG_AW   = REG_AW_DEF,
    parameter int DEPTH    = 4,
    parameter int LOAD_LAT = LOAD_LAT_DEF,
    parameter int MDU_LAT  = MDU_LAT_DEF,
    parameter int CW       = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       id_valid,
    input  logic [REG_AW-1:0]          id_rs,
    input  logic [REG_AW-1:0]          id_rt,
    input  logic                       id_use_rs,
    input  logic                       id_use_rt,
    input  logic [REG_AW-1:0]          id_rd,
    input  logic                       id_wr,
    input  logic                       id_is_load,
    input  logic                       id_is_mdu,
    input  logic                       flush,
    output logic                       PCWr,
    output logic                       IF_IDWr,
    output logic                       ID_EXMux,
    output logic [$clog2(DEPTH+1)-1:0] pend_cnt,
    output logic [15:0]                stall_cnt
);
    localparam int PW = $clog2(DEPTH+1);

    ins_cls_t         cls;
    logic [DEPTH-1:0] valid, mdu, h_rs, h_rt, h_rd, free, alloc;
    logic             multi, raw, waw, strc, mduh, stall, do_alloc;
    logic [CW-1:0]    alloc_cnt;

    assign cls      = ins_cls(id_is_load, id_is_mdu);
    assign multi    = cls != CLS_ALU;
    assign raw      = id_valid & ((id_use_rs & |h_rs) | (id_use_rt & |h_rt));
    assign waw      = id_valid & id_wr & |h_rd;
    // Entries freeing on this edge still count as occupied.
    assign strc     = id_valid & multi & (&valid);
    assign mduh     = id_valid & (cls == CLS_MDU) & |mdu;
    assign stall    = (raw | waw | strc | mduh) & ~flush;
    assign PCWr     = ~stall;
    assign IF_IDWr  = ~stall;
    assign ID_EXMux = ~stall;
    assign do_alloc = id_valid & ~stall & ~flush & id_wr & (id_rd != '0) & multi;
    assign free     = ~valid;
    // Isolate the lowest set bit of free to pick the lowest-index free entry.
    assign alloc     = do_alloc ? (free & (~free + 1'b1)) : '0;
    assign alloc_cnt = (cls == CLS_MDU) ? CW'(MDU_LAT) : CW'(LOAD_LAT);

    for (genvar i = 0; i < DEPTH; i++) begin : g_ent
        hazard_sb_entry #(.REG_AW(REG_AW), .CW(CW)) u_ent (
            .clk(clk), .rst_n(rst_n), .alloc(alloc[i]), .alloc_reg(id_rd),
            .alloc_cnt(alloc_cnt), .alloc_mdu(id_is_mdu), .rs(id_rs), .rt(id_rt), .rd(id_rd),
            .valid(valid[i]), .is_mdu(mdu[i]), .hit_rs(h_rs[i]), .hit_rt(h_rt[i]), .hit_rd(h_rd[i])
        );
    end

    always_comb begin
        pend_cnt = '0;
        for (int j = 0; j < DEPTH; j++) pend_cnt = pend_cnt + PW'(valid[j]);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) stall_cnt <= '0;
        else if (stall && stall_cnt != 16'hFFFF) stall_cnt <= stall_cnt + 16'd1;
    end
endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb_hazard_scoreboard: directed scoreboard bench for hazard_scoreboard (default and DEPTH=2 builds).
module tb_hazard_scoreboard;
    logic       clk = 0;
    logic       rst_n = 0;
    logic       id_valid = 0, id_use_rs = 0, id_use_rt = 0, id_wr = 0, id_is_load = 0, id_is_mdu = 0, flush = 0;
    logic [4:0] id_rs = 0, id_rt = 0, id_rd = 0;
    logic       pc_a, ifid_a, idex_a, pc_b, ifid_b, idex_b;
    logic [2:0] pend_a;
    logic [1:0] pend_b;
    logic [15:0] sc_a, sc_b;
    int n_cmp = 0, n_err = 0;
    bit sel = 0;

    typedef struct { string tag; logic [2:0] ctl; int pend; } exp_t;
    exp_t q[$];

    always #5 clk = ~clk;

    hazard_scoreboard u_a (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_rd(id_rd), .id_wr(id_wr),
        .id_is_load(id_is_load), .id_is_mdu(id_is_mdu), .flush(flush),
        .PCWr(pc_a), .IF_IDWr(ifid_a), .ID_EXMux(idex_a), .pend_cnt(pend_a), .stall_cnt(sc_a)
    );

    hazard_scoreboard #(.DEPTH(2), .LOAD_LAT(7), .MDU_LAT(15)) u_b (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_rd(id_rd), .id_wr(id_wr),
        .id_is_load(id_is_load), .id_is_mdu(id_is_mdu), .flush(flush),
        .PCWr(pc_b), .IF_IDWr(ifid_b), .ID_EXMux(idex_b), .pend_cnt(pend_b), .stall_cnt(sc_b)
    );

    task automatic check(input string tag, input int obs, input int exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int ctl_obs();
        return sel ? int'({pc_b, ifid_b, idex_b}) : int'({pc_a, ifid_a, idex_a});
    endfunction

    function automatic int pend_obs();
        return sel ? int'(pend_b) : int'(pend_a);
    endfunction

    // Drive one ID cycle, queue the expected outputs, compare at the falling edge.
    task automatic step(input string tag, input logic v, input logic [4:0] rs, input logic urs,
                        input logic [4:0] rt, input logic urt, input logic [4:0] rd, input logic wr,
                        input logic ld, input logic md, input logic fl, input logic adv, input int pend);
        exp_t e;
        id_valid = v; id_rs = rs; id_use_rs = urs; id_rt = rt; id_use_rt = urt;
        id_rd = rd; id_wr = wr; id_is_load = ld; id_is_mdu = md; flush = fl;
        q.push_back('{tag, {3{adv}}, pend});
        @(negedge clk);
        e = q.pop_front();
        check({e.tag, ".ctl"}, ctl_obs(), int'(e.ctl));
        check({e.tag, ".pend"}, pend_obs(), e.pend);
        @(posedge clk); #1;
    endtask

    task automatic idle(input string tag, input int pend);
        step(tag, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, pend);
    endtask

    task automatic do_reset();
        id_valid = 0; flush = 0;
        rst_n = 0;
        @(negedge clk);
        check("rst.ctl", ctl_obs(), 7);
        check("rst.pend", pend_obs(), 0);
        rst_n = 1;
        @(posedge clk); #1;
    endtask

    initial begin
        do_reset();
        check("rst.sc_a", int'(sc_a), 0);

        // load $5, dependent add reads $5 through rt
        step("ld5",   1, 0, 0, 0, 0, 5, 1, 1, 0, 0, 1, 0);
        step("add.s", 1, 6, 1, 5, 1, 7, 1, 0, 0, 0, 0, 1);
        step("add.g", 1, 6, 1, 5, 1, 7, 1, 0, 0, 0, 1, 0);
        idle("ld.idle", 0);
        check("ld.sc", int'(sc_a), 1);

        // mult $8 then consumer, then back-to-back MDU ops
        do_reset();
        step("mul8", 1, 1, 1, 2, 1, 8, 1, 0, 1, 0, 1, 0);
        for (int i = 0; i < 4; i++) step("use8.s", 1, 8, 1, 0, 0, 3, 1, 0, 0, 0, 0, 1);
        step("use8.g", 1, 8, 1, 0, 0, 3, 1, 0, 0, 0, 1, 0);
        step("mul9", 1, 1, 1, 2, 1, 9, 1, 0, 1, 0, 1, 0);
        for (int i = 0; i < 4; i++) step("mul10.s", 1, 1, 1, 2, 1, 10, 1, 0, 1, 0, 0, 1);
        step("mul10.g", 1, 1, 1, 2, 1, 10, 1, 0, 1, 0, 1, 0);
        idle("mul10.pend", 1);
        check("mdu.sc", int'(sc_a), 8);

        // writes to $0 never allocate or match
        do_reset();
        step("ld0",  1, 0, 0, 0, 0, 0, 1, 1, 0, 0, 1, 0);
        step("rd0",  1, 0, 1, 0, 1, 4, 1, 0, 0, 0, 1, 0);
        idle("r0.idle", 0);

        // flush suppresses stall and allocation
        do_reset();
        step("ld5f", 1, 0, 0, 0, 0, 5, 1, 1, 0, 0, 1, 0);
        step("fl",   1, 5, 1, 0, 0, 5, 1, 1, 0, 1, 1, 1);
        idle("fl.idle", 0);
        check("fl.sc", int'(sc_a), 0);

        // async reset mid-countdown
        do_reset();
        step("mul8r", 1, 0, 0, 0, 0, 8, 1, 0, 1, 0, 1, 0);
        idle("cnt4", 1);
        idle("cnt3", 1);
        #2 rst_n = 0;
        #1 check("arst.pend", int'(pend_a), 0);
        check("arst.ctl", ctl_obs(), 7);
        @(negedge clk); rst_n = 1;
        @(posedge clk); #1;
        step("arst.use", 1, 8, 1, 0, 0, 3, 1, 0, 0, 0, 1, 0);
        check("arst.sc", int'(sc_a), 0);

        // DEPTH=2 build: structural stall on third load
        sel = 1;
        do_reset();
        step("b.ld1", 1, 0, 0, 0, 0, 1, 1, 1, 0, 0, 1, 0);
        step("b.ld2", 1, 0, 0, 0, 0, 2, 1, 1, 0, 0, 1, 1);
        for (int i = 0; i < 6; i++) step("b.ld3.s", 1, 0, 0, 0, 0, 3, 1, 1, 0, 0, 0, 2);
        step("b.ld3.g", 1, 0, 0, 0, 0, 3, 1, 1, 0, 0, 1, 1);
        idle("b.idle", 1);
        check("b.sc", int'(sc_b), 6);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
